// File: rtl/instruction_decode_queue.sv
// RV32IM decode stage with a DEPTH-entry circular queue between IFD and IX.
// Decoded records (plus an illegal flag) are buffered and handed to IX over a
// valid/ready handshake. The block supports flush-on-branch and reports occupancy.

package instruction_decode_queue_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_inc;
  } ifd_id_inf_t;

  localparam logic [3:0] EXE_PIPE_INVALID = 4'b0000;
  localparam logic [3:0] EXE_PIPE_ALU     = 4'b0001;
  localparam logic [3:0] EXE_PIPE_LSU     = 4'b0010;
  localparam logic [3:0] EXE_PIPE_MUL     = 4'b0100;
  localparam logic [3:0] EXE_PIPE_DIV     = 4'b1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  rd;
    logic [31:0] imm_ext;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        alu_src;
    logic        register_write;
    logic        mem_load;
    logic        mem_store;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        icache_invalidate;
    logic [3:0]  exe_pipe;
  } id_ix_inf_t;
endpackage

// Protocol checks for the queue handshake.
module instruction_decode_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          ifd_valid,
  input logic          ifd_ready,
  input logic          id_valid,
  input logic          ix_ready,
  input logic [CW-1:0] count
);
  a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
    !(ifd_valid && ifd_ready && (count == CW'(DEPTH))));
  a_no_deq_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(id_valid && ix_ready && (count == CW'(0))));
  a_depth_pow2: assert property (@(posedge clk)
    ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= 2));
endmodule

module instruction_decode_queue
  import instruction_decode_queue_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter bit ILLEGAL_CHECK = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_do_branch,
  input  logic                         ifd_valid,
  input  ifd_id_inf_t                  ifd_id_inf,
  output logic                         ifd_ready,
  output logic                         id_valid,
  output id_ix_inf_t                   id_ix_inf,
  output logic                         id_illegal,
  input  logic                         ix_ready,
  output logic [$clog2(DEPTH+1)-1:0]   id_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_MISC   = 7'b0001111;

  typedef struct packed {
    logic       illegal;
    id_ix_inf_t rec;
  } entry_t;

  entry_t          mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic            id_valid_r;
  logic            ifd_ready_r;
  logic            enq_s;
  logic            deq_s;
  logic            flush_s;

  logic [31:0]     instr_s;
  logic [6:0]      opcode_s;
  logic [6:0]      funct7_s;
  logic [31:0]     imm_i_s;
  logic [31:0]     imm_s_s;
  logic [31:0]     imm_b_s;
  logic [31:0]     imm_u_s;
  logic [31:0]     imm_j_s;
  logic [31:0]     imm_sh_s;
  id_ix_inf_t      dec_s;
  logic            dec_illegal_s;

  assign instr_s  = ifd_id_inf.instr;
  assign opcode_s = instr_s[6:0];
  assign funct7_s = instr_s[31:25];
  assign imm_i_s  = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s  = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s  = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s  = {instr_s[31:12], 12'b0};
  assign imm_j_s  = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};
  assign imm_sh_s = {27'b0, instr_s[24:20]};

  // Decode the incoming instruction into an IX record and an illegal flag.
  always_comb begin
    dec_s          = '0;
    dec_illegal_s  = 1'b0;
    dec_s.pc       = ifd_id_inf.pc;
    dec_s.pc_inc   = ifd_id_inf.pc_inc;
    dec_s.a1       = instr_s[19:15];
    dec_s.a2       = instr_s[24:20];
    dec_s.rd       = instr_s[11:7];
    dec_s.funct3   = instr_s[14:12];
    dec_s.funct7_5 = instr_s[30];
    case (opcode_s)
      OP_LOAD: begin
        dec_s.imm_ext = imm_i_s;  dec_s.alu_src = 1'b1; dec_s.register_write = 1'b1;
        dec_s.mem_load = 1'b1;    dec_s.exe_pipe = EXE_PIPE_LSU;
      end
      OP_STORE: begin
        dec_s.imm_ext = imm_s_s;  dec_s.alu_src = 1'b1;
        dec_s.mem_store = 1'b1;   dec_s.exe_pipe = EXE_PIPE_LSU;
      end
      OP_BRANCH: begin
        dec_s.imm_ext = imm_b_s;  dec_s.branch = 1'b1; dec_s.exe_pipe = EXE_PIPE_ALU;
      end
      OP_IMM: begin
        // Shift-immediates carry a zero-extended shamt instead of a signed immediate.
        if (instr_s[13:12] == 2'b01) begin
          dec_s.imm_ext = imm_sh_s;
        end else begin
          dec_s.imm_ext = imm_i_s;
        end
        dec_s.alu_src = 1'b1; dec_s.register_write = 1'b1; dec_s.exe_pipe = EXE_PIPE_ALU;
      end
      OP_REG: begin
        dec_s.register_write = 1'b1;
        if (funct7_s[0]) begin
          dec_s.exe_pipe = instr_s[14] ? EXE_PIPE_DIV : EXE_PIPE_MUL;
        end else begin
          dec_s.exe_pipe = EXE_PIPE_ALU;
        end
        if (ILLEGAL_CHECK && !((funct7_s == 7'b0000000) || (funct7_s == 7'b0100000) ||
                               (funct7_s == 7'b0000001))) begin
          dec_illegal_s = 1'b1;
        end else begin
          dec_illegal_s = 1'b0;
        end
      end
      OP_JAL: begin
        dec_s.imm_ext = imm_j_s;  dec_s.alu_src = 1'b1; dec_s.register_write = 1'b1;
        dec_s.jal = 1'b1;         dec_s.exe_pipe = EXE_PIPE_ALU;
      end
      OP_JALR: begin
        dec_s.imm_ext = imm_i_s;  dec_s.alu_src = 1'b1; dec_s.register_write = 1'b1;
        dec_s.jalr = 1'b1;        dec_s.exe_pipe = EXE_PIPE_ALU;
      end
      OP_LUI: begin
        dec_s.imm_ext = imm_u_s;  dec_s.alu_src = 1'b1; dec_s.register_write = 1'b1;
        dec_s.lui = 1'b1;         dec_s.exe_pipe = EXE_PIPE_ALU;
      end
      OP_AUIPC: begin
        dec_s.imm_ext = imm_u_s;  dec_s.alu_src = 1'b1; dec_s.register_write = 1'b1;
        dec_s.auipc = 1'b1;       dec_s.exe_pipe = EXE_PIPE_ALU;
      end
      OP_MISC: begin
        dec_s.imm_ext = imm_i_s;  dec_s.exe_pipe = EXE_PIPE_ALU;
        dec_s.icache_invalidate = (instr_s[14:12] == 3'b001);
      end
      default: begin
        // Unknown opcode: travels as a no-op, flagged only when checking is enabled.
        dec_s.exe_pipe = EXE_PIPE_INVALID;
        dec_illegal_s  = ILLEGAL_CHECK;
      end
    endcase
    if (dec_s.rd == 5'd0) begin
      dec_s.register_write = 1'b0;
    end else begin
      dec_s.register_write = dec_s.register_write;
    end
    if (dec_illegal_s) begin
      dec_s.register_write = 1'b0; dec_s.mem_load = 1'b0; dec_s.mem_store = 1'b0;
      dec_s.branch = 1'b0;         dec_s.jal = 1'b0;      dec_s.jalr = 1'b0;
      dec_s.exe_pipe = EXE_PIPE_INVALID;
    end else begin
      dec_s.exe_pipe = dec_s.exe_pipe;
    end
  end

  assign flush_s = rst || wb_do_branch;
  assign enq_s   = ifd_valid && ifd_ready_r;
  assign deq_s   = id_valid_r && ix_ready;

  // Next occupancy from the enqueue/dequeue pair.
  always_comb begin
    count_next_s = count_r;
    if (enq_s && !deq_s) begin
      count_next_s = count_r + CW'(1);
    end else if (!enq_s && deq_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, occupancy and registered handshake flags; flush and reset clear them.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      id_valid_r  <= 1'b0;
      ifd_ready_r <= 1'b1;
    end else begin
      if (enq_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (deq_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r     <= count_next_s;
      id_valid_r  <= (count_next_s != CW'(0));
      ifd_ready_r <= (count_next_s != FULL_C);
    end
  end

  // Queue storage; writes in a flush cycle are dropped.
  always_ff @(posedge clk) begin
    if (enq_s && !flush_s) begin
      mem_r[wr_ptr_r] <= '{illegal: dec_illegal_s, rec: dec_s};
    end
  end

  assign ifd_ready  = ifd_ready_r;
  assign id_valid   = id_valid_r;
  assign id_count   = count_r;
  assign id_ix_inf  = mem_r[rd_ptr_r].rec;
  assign id_illegal = mem_r[rd_ptr_r].illegal && id_valid_r;

  instruction_decode_queue_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk(clk), .rst(rst), .ifd_valid(ifd_valid), .ifd_ready(ifd_ready_r),
    .id_valid(id_valid_r), .ix_ready(ix_ready), .count(count_r)
  );
endmodule

// File: tb/tb_instruction_decode_queue.sv
// Bench for instruction_decode_queue: decode vector table, directed queue
// sequences and randomized traffic against a queue-based reference model.
module tb_instruction_decode_queue;
  import instruction_decode_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_do_branch = 1'b0;
  logic        ifd_valid = 1'b0;
  ifd_id_inf_t ifd_id_inf = '0;
  logic        ix_ready = 1'b0;

  logic        ifd_ready, id_valid, id_illegal;
  id_ix_inf_t  id_ix_inf;
  logic [2:0]  id_count;
  logic        ifd_ready_nc, id_valid_nc, id_illegal_nc;
  id_ix_inf_t  id_ix_inf_nc;
  logic [2:0]  id_count_nc;

  int checks = 0;
  int errors = 0;
  bit model_known = 1'b0;

  typedef struct packed {
    logic       ill;
    id_ix_inf_t rec;
  } exp_t;

  exp_t mq0[$];
  exp_t mq1[$];

  always #5 clk = ~clk;

  instruction_decode_queue #(.DEPTH(DEPTH), .ILLEGAL_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .wb_do_branch(wb_do_branch), .ifd_valid(ifd_valid),
    .ifd_id_inf(ifd_id_inf), .ifd_ready(ifd_ready), .id_valid(id_valid),
    .id_ix_inf(id_ix_inf), .id_illegal(id_illegal), .ix_ready(ix_ready), .id_count(id_count)
  );

  instruction_decode_queue #(.DEPTH(DEPTH), .ILLEGAL_CHECK(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .wb_do_branch(wb_do_branch), .ifd_valid(ifd_valid),
    .ifd_id_inf(ifd_id_inf), .ifd_ready(ifd_ready_nc), .id_valid(id_valid_nc),
    .id_ix_inf(id_ix_inf_nc), .id_illegal(id_illegal_nc), .ix_ready(ix_ready), .id_count(id_count_nc)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode built from the instruction-set rules, using arithmetic on the word.
  function automatic exp_t model_decode(input logic [31:0] instr, input logic [31:0] pc, input bit check);
    exp_t e;
    logic [6:0] op;
    logic [6:0] f7;
    logic [31:0] w;
    e  = '0;
    op = instr[6:0];
    f7 = instr[31:25];
    e.rec.pc       = pc;
    e.rec.pc_inc   = pc + 32'd4;
    e.rec.a1       = instr[19:15];
    e.rec.a2       = instr[24:20];
    e.rec.rd       = instr[11:7];
    e.rec.funct3   = instr[14:12];
    e.rec.funct7_5 = instr[30];
    case (op)
      7'h03: begin e.rec.exe_pipe = EXE_PIPE_LSU; e.rec.mem_load = 1'b1; e.rec.register_write = 1'b1;
                   e.rec.alu_src = 1'b1; e.rec.imm_ext = 32'($signed(instr) >>> 20); end
      7'h23: begin e.rec.exe_pipe = EXE_PIPE_LSU; e.rec.mem_store = 1'b1; e.rec.alu_src = 1'b1;
                   w = 32'($signed(instr) >>> 25);
                   e.rec.imm_ext = (w << 5) | 32'(instr[11:7]); end
      7'h63: begin e.rec.exe_pipe = EXE_PIPE_ALU; e.rec.branch = 1'b1;
                   w = 32'($signed(instr) >>> 31);
                   e.rec.imm_ext = (w << 12) | (32'(instr[7]) << 11) | (32'(instr[30:25]) << 5)
                                   | (32'(instr[11:8]) << 1); end
      7'h13: begin e.rec.exe_pipe = EXE_PIPE_ALU; e.rec.register_write = 1'b1; e.rec.alu_src = 1'b1;
                   if (instr[14:12] == 3'd1 || instr[14:12] == 3'd5) e.rec.imm_ext = 32'(instr[24:20]);
                   else e.rec.imm_ext = 32'($signed(instr) >>> 20); end
      7'h33: begin e.rec.register_write = 1'b1;
                   if (!f7[0]) e.rec.exe_pipe = EXE_PIPE_ALU;
                   else if (instr[14]) e.rec.exe_pipe = EXE_PIPE_DIV;
                   else e.rec.exe_pipe = EXE_PIPE_MUL;
                   if (check && !(f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01)) e.ill = 1'b1; end
      7'h6F: begin e.rec.exe_pipe = EXE_PIPE_ALU; e.rec.jal = 1'b1; e.rec.register_write = 1'b1;
                   e.rec.alu_src = 1'b1; w = 32'($signed(instr) >>> 31);
                   e.rec.imm_ext = (w << 20) | (32'(instr[19:12]) << 12) | (32'(instr[20]) << 11)
                                   | (32'(instr[30:21]) << 1); end
      7'h67: begin e.rec.exe_pipe = EXE_PIPE_ALU; e.rec.jalr = 1'b1; e.rec.register_write = 1'b1;
                   e.rec.alu_src = 1'b1; e.rec.imm_ext = 32'($signed(instr) >>> 20); end
      7'h37: begin e.rec.exe_pipe = EXE_PIPE_ALU; e.rec.lui = 1'b1; e.rec.register_write = 1'b1;
                   e.rec.alu_src = 1'b1; e.rec.imm_ext = instr & 32'hFFFF_F000; end
      7'h17: begin e.rec.exe_pipe = EXE_PIPE_ALU; e.rec.auipc = 1'b1; e.rec.register_write = 1'b1;
                   e.rec.alu_src = 1'b1; e.rec.imm_ext = instr & 32'hFFFF_F000; end
      7'h0F: begin e.rec.exe_pipe = EXE_PIPE_ALU; e.rec.imm_ext = 32'($signed(instr) >>> 20);
                   e.rec.icache_invalidate = (instr[14:12] == 3'd1); end
      default: e.ill = check;
    endcase
    if (instr[11:7] == 5'd0) e.rec.register_write = 1'b0;
    if (e.ill) begin
      e.rec.register_write = 1'b0; e.rec.mem_load = 1'b0; e.rec.mem_store = 1'b0;
      e.rec.branch = 1'b0; e.rec.jal = 1'b0; e.rec.jalr = 1'b0;
      e.rec.exe_pipe = EXE_PIPE_INVALID;
    end
    return e;
  endfunction

  task automatic check_outputs();
    chk("id_valid", 256'(id_valid), 256'(mq0.size() != 0));
    chk("ifd_ready", 256'(ifd_ready), 256'(mq0.size() != DEPTH));
    chk("id_count", 256'(id_count), 256'(mq0.size()));
    chk("id_valid_nc", 256'(id_valid_nc), 256'(mq1.size() != 0));
    chk("id_count_nc", 256'(id_count_nc), 256'(mq1.size()));
    if (mq0.size() != 0) begin
      chk("head_rec", 256'(id_ix_inf), 256'(mq0[0].rec));
      chk("head_illegal", 256'(id_illegal), 256'(mq0[0].ill));
      chk("head_rec_nc", 256'(id_ix_inf_nc), 256'(mq1[0].rec));
      chk("head_illegal_nc", 256'(id_illegal_nc), 256'(mq1[0].ill));
    end else begin
      chk("idle_illegal", 256'(id_illegal), 256'(0));
    end
  endtask

  // One clock: drive, check at the falling edge, update the model at the rising edge.
  task automatic step(input logic r, input logic fl, input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic ixr);
    bit enq, deq;
    rst = r; wb_do_branch = fl; ifd_valid = v; ix_ready = ixr;
    ifd_id_inf = '{instr: instr, pc: pc, pc_inc: pc + 32'd4};
    @(negedge clk);
    if (model_known) check_outputs();
    enq = v && (mq0.size() < DEPTH);
    deq = (mq0.size() != 0) && ixr;
    @(posedge clk);
    if (r || fl) begin
      mq0.delete(); mq1.delete();
      if (r) model_known = 1'b1;
    end else begin
      if (deq) begin void'(mq0.pop_front()); void'(mq1.pop_front()); end
      if (enq) begin
        mq0.push_back(model_decode(instr, pc, 1'b1));
        mq1.push_back(model_decode(instr, pc, 1'b0));
      end
    end
    #1;
  endtask

  task automatic idle(input logic ixr);
    step(1'b0, 1'b0, 1'b0, 32'h0000_0013, 32'h0, ixr);
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic ixr);
    step(1'b0, 1'b0, 1'b1, instr, pc, ixr);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rw;
    logic        alu_src;
    logic [3:0]  pipe;
    logic        ill;
    logic        ic;
    logic [3:0]  pipe_nc;
    logic        ill_nc;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] ops[12];
    logic [6:0] f7s[4];
    ops = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h7F, 7'h5B};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h40};
    w = $urandom();
    w[6:0] = ops[$urandom_range(11, 0)];
    if (w[6:0] == 7'h33) w[31:25] = f7s[$urandom_range(3, 0)];
    return w;
  endfunction

  initial begin
    vecs[0]  = '{32'h0050_0093, 5'd1,  32'd5,         1'b1, 1'b1, EXE_PIPE_ALU,     1'b0, 1'b0, EXE_PIPE_ALU,     1'b0};
    vecs[1]  = '{32'h0220_81B3, 5'd3,  32'd0,         1'b1, 1'b0, EXE_PIPE_MUL,     1'b0, 1'b0, EXE_PIPE_MUL,     1'b0};
    vecs[2]  = '{32'h0220_C1B3, 5'd3,  32'd0,         1'b1, 1'b0, EXE_PIPE_DIV,     1'b0, 1'b0, EXE_PIPE_DIV,     1'b0};
    vecs[3]  = '{32'h0000_007F, 5'd0,  32'd0,         1'b0, 1'b0, EXE_PIPE_INVALID, 1'b1, 1'b0, EXE_PIPE_INVALID, 1'b0};
    vecs[4]  = '{32'h8020_8033, 5'd0,  32'd0,         1'b0, 1'b0, EXE_PIPE_INVALID, 1'b1, 1'b0, EXE_PIPE_ALU,     1'b0};
    vecs[5]  = '{32'h0050_0013, 5'd0,  32'd5,         1'b0, 1'b1, EXE_PIPE_ALU,     1'b0, 1'b0, EXE_PIPE_ALU,     1'b0};
    vecs[6]  = '{32'h0000_100F, 5'd0,  32'd0,         1'b0, 1'b0, EXE_PIPE_ALU,     1'b0, 1'b1, EXE_PIPE_ALU,     1'b0};
    vecs[7]  = '{32'hFE20_AE23, 5'd28, 32'hFFFF_FFFC, 1'b0, 1'b1, EXE_PIPE_LSU,     1'b0, 1'b0, EXE_PIPE_LSU,     1'b0};
    vecs[8]  = '{32'h1234_52B7, 5'd5,  32'h1234_5000, 1'b1, 1'b1, EXE_PIPE_ALU,     1'b0, 1'b0, EXE_PIPE_ALU,     1'b0};
    vecs[9]  = '{32'h0030_9093, 5'd1,  32'd3,         1'b1, 1'b1, EXE_PIPE_ALU,     1'b0, 1'b0, EXE_PIPE_ALU,     1'b0};
    vecs[10] = '{32'h0020_8463, 5'd8,  32'd8,         1'b0, 1'b0, EXE_PIPE_ALU,     1'b0, 1'b0, EXE_PIPE_ALU,     1'b0};

    @(posedge clk); #1;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_id_valid", 256'(id_valid), 256'(0));
    chk("rst_ifd_ready", 256'(ifd_ready), 256'(1));
    chk("rst_id_count", 256'(id_count), 256'(0));
    chk("rst_id_illegal", 256'(id_illegal), 256'(0));

    // Decode table: one instruction through an empty queue each
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      push(vecs[i].instr, 32'h100 + 32'(i * 4), 1'b0);
      chk("vec_valid", 256'(id_valid), 256'(1));
      chk("vec_count", 256'(id_count), 256'(1));
      chk("vec_pc", 256'(id_ix_inf.pc), 256'(32'h100 + 32'(i * 4)));
      chk("vec_rd", 256'(id_ix_inf.rd), 256'(vecs[i].rd));
      chk("vec_imm", 256'(id_ix_inf.imm_ext), 256'(vecs[i].imm));
      chk("vec_rw", 256'(id_ix_inf.register_write), 256'(vecs[i].rw));
      chk("vec_alu_src", 256'(id_ix_inf.alu_src), 256'(vecs[i].alu_src));
      chk("vec_pipe", 256'(id_ix_inf.exe_pipe), 256'(vecs[i].pipe));
      chk("vec_illegal", 256'(id_illegal), 256'(vecs[i].ill));
      chk("vec_icinv", 256'(id_ix_inf.icache_invalidate), 256'(vecs[i].ic));
      chk("vec_pipe_nc", 256'(id_ix_inf_nc.exe_pipe), 256'(vecs[i].pipe_nc));
      chk("vec_illegal_nc", 256'(id_illegal_nc), 256'(vecs[i].ill_nc));
      idle(1'b1);
      chk("vec_drained", 256'(id_valid), 256'(0));
    end

    // Fill under backpressure, pop with a blocked push at full, then drain
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    push(32'h0220_81B3, 32'h200, 1'b0);
    push(32'h0010_0093, 32'h204, 1'b0);
    push(32'h0020_0093, 32'h208, 1'b0);
    push(32'h0030_0093, 32'h20C, 1'b0);
    chk("full_ready", 256'(ifd_ready), 256'(0));
    chk("full_count", 256'(id_count), 256'(4));
    chk("full_head_pipe", 256'(id_ix_inf.exe_pipe), 256'(EXE_PIPE_MUL));
    chk("full_head_rd", 256'(id_ix_inf.rd), 256'(3));
    push(32'h0040_0093, 32'h210, 1'b1);
    chk("pop_ready", 256'(ifd_ready), 256'(1));
    chk("pop_count", 256'(id_count), 256'(3));
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_valid", 256'(id_valid), 256'(0));

    // Steady state at occupancy 2 across pointer wrap
    push(32'h0050_0093, 32'h300, 1'b0);
    push(32'h0060_0093, 32'h304, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push(32'h0070_0093 + 32'(i << 20), 32'h308 + 32'(i * 4), 1'b1);
      chk("steady_count", 256'(id_count), 256'(2));
    end
    idle(1'b1); idle(1'b1); idle(1'b0);

    // Flush at full with a same-cycle push
    for (int i = 0; i < 4; i++) push(32'h0010_0093, 32'h400 + 32'(i * 4), 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0ff0_0093, 32'h500, 1'b1);
    chk("flush_count", 256'(id_count), 256'(0));
    chk("flush_valid", 256'(id_valid), 256'(0));
    idle(1'b0);
    chk("flush_no_ghost", 256'(id_valid), 256'(0));

    // Reset and flush together while partially full
    push(32'h0010_0093, 32'h600, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h0020_0093, 32'h604, 1'b0);
    chk("rstflush_count", 256'(id_count), 256'(0));

    // Randomized traffic against the reference queue
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63, 0) == 0), ($urandom_range(31, 0) == 0), 1'($urandom_range(1, 0)),
           rand_instr(), $urandom() & 32'hFFFF_FFFC, ($urandom_range(2, 0) != 0));
    end
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
